// File: rtl/alu_64.sv
// 64-bit execute-stage ALU: pass-B, add, sub, and/or/xor with registered
// result and negative/zero/overflow/carry_out flags (one cycle of latency).
module alu_64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam logic [2:0] OP_PASS_B = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_AND    = 3'b100;
    localparam logic [2:0] OP_OR     = 3'b101;
    localparam logic [2:0] OP_XOR    = 3'b110;

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic             carry_into_msb;
    logic [WIDTH-1:0] logic_bits;

    logic [WIDTH-1:0] result_next;
    logic             overflow_next;
    logic             carry_next;

    logic [WIDTH-1:0] result_reg;
    logic             negative_reg;
    logic             zero_reg;
    logic             overflow_reg;
    logic             carry_reg;

    // Single shared adder; subtraction is A + ~B + 1.
    assign sub     = (cntrl == OP_SUB);
    assign b_eff   = B ^ {WIDTH{sub}};
    assign sum_ext = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

    // The sum bit at the MSB is a ^ b ^ cin, so cin can be recovered from it.
    assign carry_into_msb = sum_ext[WIDTH-1] ^ A[WIDTH-1] ^ b_eff[WIDTH-1];

    // Per-bit logic unit selected by the low opcode bits (00 and, 01 or, 10 xor).
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic
            always_comb begin
                logic_bits[gi] = 1'b0;
                case (cntrl[1:0])
                    2'b00:   logic_bits[gi] = A[gi] & B[gi];
                    2'b01:   logic_bits[gi] = A[gi] | B[gi];
                    2'b10:   logic_bits[gi] = A[gi] ^ B[gi];
                    default: logic_bits[gi] = 1'b0;
                endcase
            end
        end
    endgenerate

    always_comb begin
        result_next   = '0;
        overflow_next = 1'b0;
        carry_next    = 1'b0;
        case (cntrl)
            OP_PASS_B: result_next = B;
            OP_ADD, OP_SUB: begin
                result_next   = sum_ext[WIDTH-1:0];
                carry_next    = sum_ext[WIDTH];
                overflow_next = carry_into_msb ^ sum_ext[WIDTH];
            end
            OP_AND, OP_OR, OP_XOR: result_next = logic_bits;
            default: result_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_reg   <= '0;
            negative_reg <= 1'b0;
            zero_reg     <= 1'b1;
            overflow_reg <= 1'b0;
            carry_reg    <= 1'b0;
        end else begin
            result_reg   <= result_next;
            negative_reg <= result_next[WIDTH-1];
            zero_reg     <= (result_next == '0);
            overflow_reg <= overflow_next;
            carry_reg    <= carry_next;
        end
    end

    assign result    = result_reg;
    assign negative  = negative_reg;
    assign zero      = zero_reg;
    assign overflow  = overflow_reg;
    assign carry_out = carry_reg;

endmodule

// File: tb/tb_alu_64.sv
// Directed and randomised checks of alu_64: reset, every opcode, flags,
// one-cycle latency and mid-stream reset.
module tb_alu_64;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] A;
    logic [63:0] B;
    logic [2:0]  cntrl;
    logic [63:0] result;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carry_out;

    int total = 0;
    int bad   = 0;

    alu_64 dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .cntrl     (cntrl),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Drive one op before a rising edge, then check result and flags just after it.
    // flags are packed {negative, zero, overflow, carry_out}.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp_res,
                          input logic [3:0] exp_flags);
        @(negedge clk);
        cntrl = op;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        check_val({tag, ".res"}, result, exp_res);
        check_val({tag, ".flg"}, {60'd0, negative, zero, overflow, carry_out}, {60'd0, exp_flags});
    endtask

    // Independent reference: overflow from operand/result sign rules, borrow from compare.
    task automatic model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output logic [3:0] f);
        logic [64:0] wide;
        logic        ov;
        logic        c;
        r  = '0;
        ov = 1'b0;
        c  = 1'b0;
        case (op)
            3'b000: r = b;
            3'b010: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[63:0];
                c    = wide[64];
                ov   = (a[63] == b[63]) && (r[63] != a[63]);
            end
            3'b011: begin
                r  = a - b;
                c  = (a >= b);
                ov = (a[63] != b[63]) && (r[63] != a[63]);
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: r = '0;
        endcase
        f = {r[63], (r == 64'd0), ov, c};
    endtask

    initial begin
        logic [63:0] er;
        logic [3:0]  ef;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [2:0]  ops [6];

        ops[0] = 3'b000; ops[1] = 3'b010; ops[2] = 3'b011;
        ops[3] = 3'b100; ops[4] = 3'b101; ops[5] = 3'b110;

        reset = 1'b1;
        A     = 64'h1111;
        B     = 64'h2222;
        cntrl = 3'b010;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset.res", result, 64'd0);
        check_val("reset.flg", {60'd0, negative, zero, overflow, carry_out}, 64'b0100);
        @(negedge clk);
        reset = 1'b0;

        run_op("passb", 3'b000, 64'h1234, 64'h8000000000000000, 64'h8000000000000000, 4'b1000);
        run_op("add_ovf", 3'b010, 64'h7FFFFFFFFFFFFFFF, 64'h7FFF000000000001,
               64'hFFFF000000000000, 4'b1010);
        run_op("add_wrap", 3'b010, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd0, 4'b0101);
        run_op("sub_eq", 3'b011, 64'd1, 64'd1, 64'd0, 4'b0101);
        run_op("sub_borrow", 3'b011, 64'd0, 64'd1, 64'hFFFFFFFFFFFFFFFF, 4'b1000);
        run_op("sub_ovf", 3'b011, 64'h8000000000000000, 64'd1, 64'h7FFFFFFFFFFFFFFF, 4'b0011);
        run_op("and", 3'b100, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 64'hF000F000F000F000, 4'b1000);
        run_op("or", 3'b101, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 64'hFFF0FFF0FFF0FFF0, 4'b1000);
        run_op("xor", 3'b110, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 64'h0FF00FF00FF00FF0, 4'b0000);
        run_op("xor_zero", 3'b110, 64'd0, 64'd0, 64'd0, 4'b0100);
        run_op("rsv111", 3'b111, 64'h5, 64'h7, 64'd0, 4'b0100);
        run_op("rsv001", 3'b001, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'd0, 4'b0100);

        // Output must hold between edges: new inputs do not show until the next edge.
        @(negedge clk);
        cntrl = 3'b000;
        B     = 64'hDEADBEEF;
        #2;
        check_val("hold.res", result, 64'd0);
        @(posedge clk);
        #1;
        check_val("latency.res", result, 64'hDEADBEEF);

        // Back-to-back: opcode changes every cycle.
        run_op("b2b_add", 3'b010, 64'd10, 64'd20, 64'd30, 4'b0000);
        run_op("b2b_sub", 3'b011, 64'd10, 64'd20, 64'hFFFFFFFFFFFFFFF6, 4'b1000);
        run_op("b2b_or", 3'b101, 64'h0F, 64'hF0, 64'hFF, 4'b0000);
        run_op("b2b_pass", 3'b000, 64'd99, 64'd0, 64'd0, 4'b0100);

        // Reset asserted with an ADD in flight discards it.
        @(negedge clk);
        cntrl = 3'b010;
        A     = 64'd5;
        B     = 64'd6;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("midrst.res", result, 64'd0);
        check_val("midrst.flg", {60'd0, negative, zero, overflow, carry_out}, 64'b0100);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("midrst_hold.res", result, 64'd0);
        @(posedge clk);
        #1;
        check_val("postrst.res", result, 64'd11);

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 100; i++) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                if (i == 0) rb = ra;
                if (i == 1) begin ra = 64'h8000000000000000; rb = 64'h8000000000000000; end
                model(ops[k], ra, rb, er, ef);
                run_op($sformatf("rnd_op%0d_%0d", ops[k], i), ops[k], ra, rb, er, ef);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_64.md
Name:
alu_64

Overview:
- 64-bit integer ALU for the datapath execute stage: pass-B, add, subtract, AND, OR and XOR.
- Also produces negative, zero, overflow and carry_out flags.
- Operands and control are sampled on the clock edge; result and flags are registered, giving one cycle of latency.
- Feeds flag/branch logic and writeback.

Parameters:
- WIDTH, 64, datapath width in bits. Only 64 is required to work.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- A  input  64  operand A.
- B  input  64  operand B.
- cntrl  input  3  operation select.
- result  output  64  registered operation result.
- negative  output  1  registered; equals result[63].
- zero  output  1  registered; 1 when result == 0.
- overflow  output  1  registered; signed overflow for add/sub.
- carry_out  output  1  registered; carry out of bit 63 for add/sub.

Behaviour:
- Opcodes:
  - 000 result = B.
  - 010 result = A + B.
  - 011 result = A - B.
  - 100 result = A & B.
  - 101 result = A | B.
  - 110 result = A ^ B.
  - 001 and 111 are reserved: result = 0.
- Latency: A, B and cntrl are sampled at rising edge N. The result and all four flags for those inputs are visible after edge N and hold until edge N+1. No handshake; a new operation can start every cycle.
- Reset: when reset = 1 at a rising edge, the registers load result = 0, negative = 0, zero = 1, overflow = 0, carry_out = 0. Reset has priority over any operation. Asserting reset mid-stream discards the in-flight sample. The first operation after reset deasserts appears one edge later.
- Arithmetic core: one 64-bit adder computes A + (B ^ {64{sub}}) + sub, where sub = 1 only for opcode 011.
  - carry_out = carry out of bit 63. For subtract, carry_out = 1 means no borrow (A >= B unsigned).
  - overflow = carry into bit 63 XOR carry out of bit 63, i.e. signed overflow.
- Flags for non-arithmetic opcodes: overflow = 0 and carry_out = 0 for 000, 1xx and reserved codes.
- negative and zero are derived from the final 64-bit result for every opcode.
- Wrap-around: sums and differences are modulo 2^64. No saturation.
- No internal state other than the output registers. Outputs change only on clock edges.

Test Plan:
- PASS_B, reset handling: apply reset for 2 cycles -> result = 0, zero = 1, other flags 0. Then cntrl = 000, A = 0x1234, B = 0x8000000000000000 -> result = 0x8000000000000000, negative = 1, zero = 0, overflow = 0, carry_out = 0 after one edge.
- ADD signed overflow: A = 0x7FFFFFFFFFFFFFFF, B = 0x7FFF000000000001 -> result = 0xFFFF000000000000, overflow = 1, carry_out = 0, negative = 1, zero = 0.
- ADD wrap to zero: A = 0xFFFFFFFFFFFFFFFF, B = 1 -> result = 0, zero = 1, carry_out = 1, overflow = 0, negative = 0.
- SUB:
  - A = 1, B = 1 -> result = 0, zero = 1, carry_out = 1, overflow = 0.
  - A = 0, B = 1 -> result = 0xFFFFFFFFFFFFFFFF, negative = 1, carry_out = 0.
  - A = 0x8000000000000000, B = 1 -> result = 0x7FFFFFFFFFFFFFFF, overflow = 1.
- Logic ops: A = 0xF0F0F0F0F0F0F0F0, B = 0xFF00FF00FF00FF00.
  - AND -> 0xF000F000F000F000.
  - OR -> 0xFFF0FFF0FFF0FFF0.
  - XOR -> 0x0FF00FF00FF00FF0.
  - All with overflow = 0 and carry_out = 0. Then A = B = 0 with XOR -> zero = 1.
- Back-to-back and mid-stream reset: change the opcode every cycle and check each result appears exactly one edge later. Assert reset during an ADD -> reset values next cycle. Also cover 100+ random A/B vectors per opcode against a reference model, and reserved opcode 111 -> result = 0, zero = 1.
